// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with a source-latency delay line and test patterns.
// Coordinates go out to the pixel source and RGB comes back SRC_LAT ticks later.
module vga_timing_pipe #(
  parameter int unsigned COLOR_BITS = 2,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned SRC_LAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [COLOR_BITS-1:0] red_in,
  input  logic [COLOR_BITS-1:0] green_in,
  input  logic [COLOR_BITS-1:0] blue_in,
  output logic [COORD_W-1:0]    xcoor,
  output logic [COORD_W-1:0]    ycoor,
  output logic                  hs,
  output logic                  vs,
  output logic                  display_active,
  output logic [COLOR_BITS-1:0] red_out,
  output logic [COLOR_BITS-1:0] green_out,
  output logic [COLOR_BITS-1:0] blue_out,
  output logic                  line_start,
  output logic                  frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_S = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SYNC_E = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_S = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SYNC_E = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_WHITE = 2'b10,
    MODE_BLACK = 2'b11
  } mode_e;

  // Everything the output register needs about one coordinate; all-zero is a blanked pixel.
  typedef struct packed {
    logic       act;
    logic       hs_a;
    logic       vs_a;
    logic       ls;
    logic       fs;
    logic [2:0] bar;
  } stage_t;

  logic [COORD_W-1:0]    h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0]    v_cnt_q, v_cnt_d;
  mode_e                 mode_q, mode_eff;
  logic                  load_mode;
  stage_t                s0, tail;
  logic                  hs_q, vs_q, act_q, ls_q, fs_q;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (enable) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign xcoor = h_cnt_q;
  assign ycoor = v_cnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s0      = '0;
    s0.act  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    s0.hs_a = (h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E);
    s0.vs_a = (v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E);
    s0.ls   = (h_cnt_q == '0);
    s0.fs   = (h_cnt_q == '0) && (v_cnt_q == '0);
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= COORD_W'(k * H_ACTIVE / 8)) s0.bar = s0.bar + 3'd1;
    end
  end

  generate
    if (SRC_LAT == 0) begin : g_no_delay
      assign tail = s0;
    end else begin : g_delay
      stage_t dly_q [SRC_LAT];
      // NOTE: the delay line is reset so the first SRC_LAT outputs after reset are blanked, not X.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SRC_LAT; i++) dly_q[i] <= '0;
        end else if (enable) begin
          dly_q[0] <= s0;
          for (int i = 1; i < SRC_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign tail = dly_q[SRC_LAT-1];
    end
  endgenerate

  // A new mode is picked up on the (0,0) tick; bypassing it lets pixel (0,0) see it when SRC_LAT=0.
  assign load_mode = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign mode_eff  = load_mode ? mode_e'(mode) : mode_q;

  always_ff @(posedge clk) begin
    if (rst)            mode_q <= MODE_PASS;
    else if (load_mode) mode_q <= mode_e'(mode);
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (tail.act) begin
      case (mode_eff)
        MODE_PASS: begin
          r_d = red_in;
          g_d = green_in;
          b_d = blue_in;
        end
        MODE_BARS: begin
          r_d = {COLOR_BITS{tail.bar[2]}};
          g_d = {COLOR_BITS{tail.bar[1]}};
          b_d = {COLOR_BITS{tail.bar[0]}};
        end
        MODE_WHITE: begin
          r_d = '1;
          g_d = '1;
          b_d = '1;
        end
        MODE_BLACK: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      act_q <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else if (enable) begin
      hs_q  <= tail.hs_a ? HS_POL : ~HS_POL;
      vs_q  <= tail.vs_a ? VS_POL : ~VS_POL;
      act_q <= tail.act;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      ls_q  <= tail.ls;
      fs_q  <= tail.fs;
    end else begin
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end
  end

  assign hs             = hs_q;
  assign vs             = vs_q;
  assign display_active = act_q;
  assign red_out        = r_q;
  assign green_out      = g_q;
  assign blue_out       = b_q;
  assign line_start     = ls_q;
  assign frame_start    = fs_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: two small-timing instances (SRC_LAT=3 active-low sync,
// SRC_LAT=0 active-high sync) checked every cycle against a tick-index model.
module tb_vga_timing_pipe;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;  // 24
  localparam int VT = VA + VFP + VSW + VBP;  // 13
  localparam int F  = HT * VT;               // 312

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       da;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       ls;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [1:0] mode;

  logic [9:0] x3, y3, x0, y0;
  logic       hs3, vs3, da3, ls3, fs3, hs0, vs0, da0, ls0, fs0;
  logic [1:0] r3, g3, b3, r0, g0, b0;
  logic [1:0] r_in3, g_in3, b_in3, r_in0, g_in0, b_in0;
  logic [1:0] p_r [3];
  logic [1:0] p_g [3];
  logic [1:0] p_b [3];

  int         n_chk = 0, n_err = 0;
  int         e = 0;
  bit         last_en = 1'b0;
  bit         chk_on = 1'b0;
  logic [1:0] modes [64];
  int         cyc = 0, fs_last = 0, en_period = 1;
  bit         fs_valid = 1'b0;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .COLOR_BITS(2), .COORD_W(10),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .SRC_LAT(3)
  ) u_lat3 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .red_in(r_in3), .green_in(g_in3), .blue_in(b_in3),
    .xcoor(x3), .ycoor(y3), .hs(hs3), .vs(vs3), .display_active(da3),
    .red_out(r3), .green_out(g3), .blue_out(b3),
    .line_start(ls3), .frame_start(fs3)
  );

  vga_timing_pipe #(
    .COLOR_BITS(2), .COORD_W(10),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .SRC_LAT(0)
  ) u_lat0 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .red_in(r_in0), .green_in(g_in0), .blue_in(b_in0),
    .xcoor(x0), .ycoor(y0), .hs(hs0), .vs(vs0), .display_active(da0),
    .red_out(r0), .green_out(g0), .blue_out(b0),
    .line_start(ls0), .frame_start(fs0)
  );

  // Zero-latency source: colour is a direct function of the coordinate.
  assign r_in0 = x0[1:0];
  assign g_in0 = y0[1:0];
  assign b_in0 = x0[1:0] + y0[1:0];

  // Three-tick source pipeline feeding the SRC_LAT=3 instance.
  always @(posedge clk) begin
    if (enable && !rst) begin
      p_r[0] <= x3[1:0] ^ y3[1:0];
      p_g[0] <= x3[1:0];
      p_b[0] <= y3[1:0];
      for (int i = 1; i < 3; i++) begin
        p_r[i] <= p_r[i-1];
        p_g[i] <= p_g[i-1];
        p_b[i] <= p_b[i-1];
      end
    end
  end
  assign r_in3 = p_r[2];
  assign g_in3 = p_g[2];
  assign b_in3 = p_b[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected output for coordinate index j (enable ticks since reset); j<0 is reset fill.
  function automatic exp_t model(input int j, input int lat, input logic hp, input logic vp);
    exp_t m;
    int   h, v, bar;
    logic act;
    m    = '0;
    m.hs = ~hp;
    m.vs = ~vp;
    if (j < 0) return m;
    h   = j % HT;
    v   = (j / HT) % VT;
    act = (h < HA) && (v < VA);
    if (h >= HA + HFP && h < HA + HFP + HSW) m.hs = hp;
    if (v >= VA + VFP && v < VA + VFP + VSW) m.vs = vp;
    m.da = act;
    m.ls = (h == 0);
    m.fs = (h == 0) && (v == 0);
    if (act) begin
      bar = h * 8 / HA;
      case (modes[(j / F) % 64])
        2'b00: begin
          if (lat == 3) begin
            m.r = 2'((h ^ v) & 3);
            m.g = 2'(h & 3);
            m.b = 2'(v & 3);
          end else begin
            m.r = 2'(h & 3);
            m.g = 2'(v & 3);
            m.b = 2'((h + v) & 3);
          end
        end
        2'b01: begin
          m.r = (bar >= 4)     ? 2'b11 : 2'b00;
          m.g = ((bar & 2) != 0) ? 2'b11 : 2'b00;
          m.b = ((bar & 1) != 0) ? 2'b11 : 2'b00;
        end
        2'b10: begin
          m.r = 2'b11;
          m.g = 2'b11;
          m.b = 2'b11;
        end
        default: ;
      endcase
    end
    return m;
  endfunction

  // Model state: enable-tick index and the mode captured at each frame's first tick.
  always @(posedge clk) begin
    last_en = 1'b0;
    if (rst) begin
      e = 0;
    end else if (enable) begin
      if (e % F == 0) modes[(e / F) % 64] = mode;
      e++;
      last_en = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t m3, m0;
    cyc++;
    if (chk_on) begin
      m3 = model(e - 4, 3, 1'b0, 1'b0);
      m0 = model(e - 1, 0, 1'b1, 1'b1);
      if (!last_en) begin
        m3.ls = 1'b0; m3.fs = 1'b0;
        m0.ls = 1'b0; m0.fs = 1'b0;
      end
      check("x3", 32'(x3), 32'(e % HT));
      check("y3", 32'(y3), 32'((e / HT) % VT));
      check("x0", 32'(x0), 32'(e % HT));
      check("y0", 32'(y0), 32'((e / HT) % VT));
      check("pix3", 32'({hs3, vs3, da3, r3, g3, b3}), 32'({m3.hs, m3.vs, m3.da, m3.r, m3.g, m3.b}));
      check("strb3", 32'({ls3, fs3}), 32'({m3.ls, m3.fs}));
      check("pix0", 32'({hs0, vs0, da0, r0, g0, b0}), 32'({m0.hs, m0.vs, m0.da, m0.r, m0.g, m0.b}));
      check("strb0", 32'({ls0, fs0}), 32'({m0.ls, m0.fs}));
      if (rst) begin
        fs_valid = 1'b0;
      end else if (fs3) begin
        if (fs_valid) check("frame_period", 32'(cyc - fs_last), 32'(F * en_period));
        fs_last  = cyc;
        fs_valid = 1'b1;
      end
    end
  end

  task automatic wait_for(input int x, input int y);
    int n;
    n = 0;
    while (!(x3 == 10'(x) && y3 == 10'(y)) && n < 8000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_x", 32'(x3), 32'(x));
    check("wait_y", 32'(y3), 32'(y));
  endtask

  initial begin
    int cnt;
    rst    = 1'b1;
    enable = 1'b0;
    mode   = 2'b00;
    @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x3", 32'(x3), 32'd0);
    check("rst_hs3", 32'(hs3), 32'd1);
    check("rst_vs3", 32'(vs3), 32'd1);
    check("rst_hs0", 32'(hs0), 32'd0);
    check("rst_rgb3", 32'({r3, g3, b3}), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;

    // Sync widths per line on both polarities.
    wait_for(0, 2);
    cnt = 0;
    repeat (HT) begin
      @(posedge clk);
      #1;
      if (!hs3) cnt++;
    end
    check("hs3_low_ticks", 32'(cnt), 32'd3);
    cnt = 0;
    repeat (HT) begin
      @(posedge clk);
      #1;
      if (hs0) cnt++;
    end
    check("hs0_high_ticks", 32'(cnt), 32'd3);

    // Mode change mid-frame is deferred to the next frame.
    wait_for(0, 7);
    mode = 2'b01;
    wait_for(9, 7);
    check("midframe_pass", 32'({r0, g0, b0}), 32'({2'd0, 2'd3, 2'd3}));
    wait_for(1, 1);
    check("bar_x0", 32'({r0, g0, b0}), 32'({2'd0, 2'd0, 2'd0}));
    wait_for(3, 1);
    check("bar_x2", 32'({r0, g0, b0}), 32'({2'd0, 2'd0, 2'd3}));
    wait_for(15, 1);
    check("bar_x14", 32'({r0, g0, b0}), 32'({2'd3, 2'd3, 2'd3}));
    wait_for(17, 1);
    check("blank_x16", 32'({da0, r0, g0, b0}), 32'd0);
    wait_for(5, 9);
    check("blank_y9", 32'({da0, r0, g0, b0}), 32'd0);

    // One enable per four clocks.
    en_period = 4;
    fs_valid  = 1'b0;
    mode      = 2'b10;
    for (int i = 0; i < 2 * F + F / 2; i++) begin
      if (i == F) mode = 2'b11;
      enable = 1'b1;
      @(posedge clk);
      #1 enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end

    // Reset mid-frame with enable high.
    enable    = 1'b1;
    en_period = 1;
    fs_valid  = 1'b0;
    mode      = 2'b00;
    wait_for(10, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_x3", 32'(x3), 32'd0);
    check("midrst_y3", 32'(y3), 32'd0);
    check("midrst_sync3", 32'({hs3, vs3}), 32'b11);
    check("midrst_sync0", 32'({hs0, vs0}), 32'b00);
    check("midrst_rgb3", 32'({da3, r3, g3, b3}), 32'd0);
    rst = 1'b0;
    repeat (F + 40) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
